// File: rtl/config_stream_loader.sv
// Byte-serial configuration loader: assembles 8-byte little-endian frames and
// drives one held write per frame on the broadcast config bus.
module config_stream_loader #(
   parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFF,
   parameter int          HOLD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_done,
   output logic [15:0] frame_count,
   output logic        busy
);

   typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);

   state_t       state_q, state_d;
   logic [2:0]   idx_q;
   logic [3:0]   hold_q;
   logic [55:0]  sr_q;        // bytes 0..6, byte 0 ends up in the low lane
   logic         ready_en_q;  // keeps in_ready low until the first edge after reset
   logic [15:0]  frame_cnt_q;
   logic         accept, last, hold_last;
   logic [31:0]  frame_addr, frame_data;

   assign accept      = in_valid & in_ready;
   assign last        = accept & (idx_q == 3'd7);
   assign hold_last   = (hold_q == HOLD_LAST);
   assign frame_addr  = sr_q[31:0];
   assign frame_data  = {in_data, sr_q[55:32]};
   assign frame_count = frame_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         COLLECT: begin
            in_ready = ready_en_q;
            busy     = (idx_q != 3'd0);
            if (last) state_d = (frame_addr == END_ADDR) ? DONE : WRITE;
         end
         WRITE: begin
            busy = 1'b1;
            if (hold_last) state_d = COLLECT;
         end
         default: state_d = DONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_en_q  <= 1'b0;
         idx_q       <= 3'd0;
         hold_q      <= 4'd0;
         sr_q        <= '0;
         config_addr <= IDLE_ADDR;
         config_data <= '0;
         config_done <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         ready_en_q <= 1'b1;
         if (accept) begin
            sr_q  <= {in_data, sr_q[55:8]};
            idx_q <= idx_q + 3'd1;   // wraps 7 -> 0 on the last byte
         end
         if (last && state_d == WRITE) begin
            config_addr <= frame_addr;
            config_data <= frame_data;
            hold_q      <= 4'd1;
            if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
         end else if (last) begin
            config_done <= 1'b1;
         end
         // config_data is intentionally left holding the last write
         if (state_q == WRITE) begin
            if (hold_last) config_addr <= IDLE_ADDR;
            else           hold_q      <= hold_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader with a write scoreboard on the bus.
module tb_config_stream_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data, d4;
   logic        in_valid, v4;
   logic        in_ready, in_ready4;
   logic [31:0] config_addr, config_data, addr4, data4;
   logic        config_done, done4, busy, busy4;
   logic [15:0] frame_count, fc4;

   always #5 clk = ~clk;

   config_stream_loader #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .config_addr(config_addr), .config_data(config_data),
      .config_done(config_done), .frame_count(frame_count), .busy(busy));

   config_stream_loader #(.HOLD_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .in_data(d4), .in_valid(v4),
      .in_ready(in_ready4), .config_addr(addr4), .config_data(data4),
      .config_done(done4), .frame_count(fc4), .busy(busy4));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_writes = 0;
   logic [15:0] exp_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard monitor: pop on the first bus cycle of each write, check hold length at its end.
   logic [31:0] prev_a;
   int          hold_n;
   wr_t         w;
   always @(negedge clk) begin
      if (!reset) begin
         prev_a = '0;
         hold_n = 0;
      end else begin
         if (config_addr !== 32'h0 && prev_a === 32'h0) begin
            n_writes++;
            hold_n = 1;
            if (sb.size() == 0) chk("unexpected_write", {32'h0, config_addr}, 64'h0);
            else begin
               w = sb.pop_front();
               chk("wr_addr", {32'h0, config_addr}, {32'h0, w.a});
               chk("wr_data", {32'h0, config_data}, {32'h0, w.d});
            end
         end else if (config_addr !== 32'h0) hold_n++;
         else if (prev_a !== 32'h0) chk("hold_len", 64'(hold_n), 64'd1);
         prev_a = config_addr;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 100 && !ok; t++) begin
         if (in_ready) ok = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input int maxgap);
      logic [63:0] fr;
      fr = {d, a};
      if (a != 32'hFFFF_FFFF) begin
         sb.push_back('{a: a, d: d});
         if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
      for (int i = 0; i < 8; i++)
         send_byte(fr[8*i +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      sb.delete();
      exp_cnt = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int held, bad;
      logic [63:0] fr4;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; v4 = 1'b0; d4 = '0; exp_cnt = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'h0, in_ready}, 64'd0);
      chk("rst_addr",  {32'h0, config_addr}, 64'd0);
      chk("rst_data",  {32'h0, config_data}, 64'd0);
      chk("rst_done",  {63'h0, config_done}, 64'd0);
      chk("rst_count", {48'h0, frame_count}, 64'd0);
      chk("rst_busy",  {63'h0, busy}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {63'h0, in_ready}, 64'd1);

      // single back-to-back frame: 03 00 04 00 02 00 00 00
      send_frame(32'h0004_0003, 32'h0000_0002, 0);
      chk("t1_addr",  {32'h0, config_addr}, 64'h0004_0003);
      chk("t1_data",  {32'h0, config_data}, 64'h2);
      chk("t1_ready", {63'h0, in_ready}, 64'd0);
      chk("t1_count", {48'h0, frame_count}, 64'd1);
      chk("t1_busy",  {63'h0, busy}, 64'd1);
      @(negedge clk);
      chk("t1_addr_idle", {32'h0, config_addr}, 64'd0);
      chk("t1_data_kept", {32'h0, config_data}, 64'h2);
      chk("t1_ready_back", {63'h0, in_ready}, 64'd1);
      chk("t1_busy_off", {63'h0, busy}, 64'd0);

      // stalled stream; next frame's byte 0 is presented while the write is held
      send_frame(32'h0005_0011, 32'hCAFE_0123, 3);
      send_frame(32'h0006_0022, 32'h8765_4321, 3);
      send_frame(32'h0007_0033, 32'h0F1E_2D3C, 3);
      repeat (3) @(negedge clk);
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);
      chk("t2_writes",   64'(n_writes), 64'd4);
      chk("t2_count",    {48'h0, frame_count}, {48'h0, exp_cnt});

      // reset after byte 5 of a frame
      for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
      chk("mid_busy", {63'h0, busy}, 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("midf_addr",  {32'h0, config_addr}, 64'd0);
      chk("midf_count", {48'h0, frame_count}, 64'd0);
      chk("midf_busy",  {63'h0, busy}, 64'd0);
      sb.delete(); exp_cnt = '0;
      @(negedge clk); reset = 1'b1; @(negedge clk);

      // reset while a write is on the bus
      send_frame(32'h0004_0044, 32'h1111_2222, 0);
      chk("midw_addr_pre", {32'h0, config_addr}, 64'h0004_0044);
      #2 reset = 1'b0;
      #1;
      chk("midw_addr",  {32'h0, config_addr}, 64'd0);
      chk("midw_count", {48'h0, frame_count}, 64'd0);
      sb.delete(); exp_cnt = '0;
      @(negedge clk); reset = 1'b1; @(negedge clk);
      send_frame(32'h0005_0001, 32'hDEAD_BEEF, 1);
      repeat (2) @(negedge clk);
      chk("post_rst_count", {48'h0, frame_count}, 64'd1);
      chk("post_rst_sb",    64'(sb.size()), 64'd0);

      // counter saturation via preload
      force dut1.frame_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut1.frame_cnt_q;
      exp_cnt = 16'hFFFE;
      held = n_writes;
      send_frame(32'h0006_0003, 32'h0000_00AA, 0);
      @(negedge clk);
      chk("sat_count1", {48'h0, frame_count}, 64'hFFFF);
      send_frame(32'h0006_0004, 32'h0000_00BB, 0);
      @(negedge clk);
      chk("sat_count2", {48'h0, frame_count}, 64'hFFFF);
      chk("sat_writes", 64'(n_writes - held), 64'd2);

      // end frame
      pulse_reset();
      send_frame(32'h0006_0002, 32'h1234_5678, 0);
      repeat (2) @(negedge clk);
      chk("end_done_pre", {63'h0, config_done}, 64'd0);
      send_frame(32'hFFFF_FFFF, 32'h0, 0);
      chk("end_done",  {63'h0, config_done}, 64'd1);
      chk("end_count", {48'h0, frame_count}, 64'd1);
      chk("end_addr",  {32'h0, config_addr}, 64'd0);
      chk("end_busy",  {63'h0, busy}, 64'd0);
      chk("end_data",  {32'h0, config_data}, 64'h1234_5678);
      bad = 0;
      in_valid = 1'b1;
      for (int t = 0; t < 25; t++) begin
         if (in_ready !== 1'b0 || config_addr !== 32'h0) bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("end_halted", 64'(bad), 64'd0);
      chk("end_done_hold", {63'h0, config_done}, 64'd1);
      chk("end_sb_empty", 64'(sb.size()), 64'd0);

      // HOLD_CYCLES = 4 instance
      pulse_reset();
      fr4 = {32'hA5A5_0001, 32'h0007_0009};
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         d4 = fr4[8*i +: 8];
         v4 = 1'b1;
         if (in_ready4 !== 1'b1) bad++;
         @(negedge clk);
      end
      v4 = 1'b0;
      chk("h4_byte_stall", 64'(bad), 64'd0);
      chk("h4_addr", {32'h0, addr4}, 64'h0007_0009);
      chk("h4_data", {32'h0, data4}, 64'hA5A5_0001);
      held = 0;
      for (int t = 0; t < 10; t++) begin
         if (addr4 !== 32'h0) begin
            held++;
            if (in_ready4 !== 1'b0 || busy4 !== 1'b1) bad++;
         end
         @(negedge clk);
      end
      chk("h4_hold", 64'(held), 64'd4);
      chk("h4_ready_busy", 64'(bad), 64'd0);
      chk("h4_ready_back", {63'h0, in_ready4}, 64'd1);
      chk("h4_count", {48'h0, fc4}, 64'd1);
      chk("h4_done", {63'h0, done4}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
